// File: rtl/count_stream_monitor.sv
// Locks onto an incrementing count stream, flags out-of-sequence words once locked.
// Latency: one cycle, all outputs registered; no backpressure, a sample is accepted every cycle sample_valid is high.
module count_stream_monitor #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       bad_q, bad_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             in_seq;
  logic [3:0]       run_upd;
  logic [3:0]       bad_upd;
  logic             lock_hit;
  logic             loss_hit;

  // Sequence is judged against the last sample, not expected_q, so the first
  // word after reset is handled by the run==0 rule rather than compared to 0.
  always_comb begin
    in_seq   = (sample_in == last_q + WIDTH'(1));
    run_upd  = (run_q == 4'd0) ? 4'd1 : (in_seq ? run_q + 4'd1 : 4'd1);
    bad_upd  = bad_q + 4'd1;
    lock_hit = sample_valid && (state_q == SEARCH) && (run_upd == LOCK_CNT);
    loss_hit = sample_valid && (state_q == LOCKED) && !in_seq && (bad_upd == LOSS_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (lock_hit) begin
      state_d = LOCKED;
    end else if (loss_hit) begin
      state_d = SEARCH;
    end
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  always_comb begin
    last_d      = last_q;
    expected_d  = expected_q;
    run_d       = run_q;
    bad_d       = bad_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (sample_valid) begin
      last_d     = sample_in;
      expected_d = sample_in + WIDTH'(1);
      if (state_q == SEARCH) begin
        run_d = run_upd;
        if (lock_hit) begin
          bad_d = 4'd0;
        end
      end else if (in_seq) begin
        bad_d = 4'd0;
      end else begin
        err_pulse_d = 1'b1;
        bad_d       = bad_upd;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
        // The offending word seeds the new search run.
        if (loss_hit) begin
          run_d = 4'd1;
        end
      end
    end
    if (clr_err) begin
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= '0;
      expected_q  <= '0;
      run_q       <= 4'd0;
      bad_q       <= 4'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      last_q      <= last_d;
      expected_q  <= expected_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_count_stream_monitor.sv
// Directed bench for count_stream_monitor with hand-computed expectations.
module tb_count_stream_monitor;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample_in;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] expected;

  int checks = 0;
  int errors = 0;

  count_stream_monitor #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .clr_err      (clr_err),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .expected     (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Presents one valid word for exactly one edge; returns #1 after that edge.
  task automatic push(input logic [7:0] v, input logic clr = 1'b0);
    sample_valid = 1'b1;
    sample_in    = v;
    clr_err      = clr;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clr_err      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] v;

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 8'd0;
    clr_err      = 1'b0;
    #12;
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_count", err_count, 0);
    check("rst_expected", expected, 0);
    rst_n = 1'b1;

    // Basic lock on 10..13
    @(negedge clk);
    push(8'd10); check("b_lock1", locked, 0);
    push(8'd11); check("b_lock2", locked, 0);
    push(8'd12); check("b_lock3", locked, 0);
    push(8'd13); check("b_lock4", locked, 1);
    check("b_expected", expected, 14);
    check("b_count", err_count, 0);

    // Lock across the wrap
    do_reset();
    push(8'd254); push(8'd255); push(8'd0);
    check("w_lock3", locked, 0);
    push(8'd1);
    check("w_lock4", locked, 1);
    check("w_expected", expected, 2);

    // Run restarts at 7
    do_reset();
    push(8'd5); push(8'd7); push(8'd8); push(8'd9);
    check("r_lock_9", locked, 0);
    push(8'd10);
    check("r_lock_10", locked, 1);

    // Single glitch while locked
    do_reset();
    push(8'd20); push(8'd21); push(8'd22); push(8'd23);
    push(8'd50);
    check("g_pulse", err_pulse, 1);
    check("g_count", err_count, 1);
    check("g_locked", locked, 1);
    check("g_expected", expected, 51);
    push(8'd51);
    check("g_pulse_off", err_pulse, 0);
    check("g_locked2", locked, 1);
    push(8'd100); push(8'd200);
    check("g_bad_cleared", locked, 1);
    check("g_count3", err_count, 3);

    // Loss of lock and relock seeded by the offending word
    do_reset();
    push(8'd20); push(8'd21); push(8'd22); push(8'd23);
    push(8'd90); check("l_pulse1", err_pulse, 1); check("l_locked1", locked, 1);
    push(8'd3);  check("l_pulse2", err_pulse, 1); check("l_locked2", locked, 1);
    push(8'd77); check("l_pulse3", err_pulse, 1);
    check("l_locked3", locked, 0);
    check("l_count", err_count, 3);
    check("l_expected", expected, 78);
    push(8'd78); check("l_pulse_search", err_pulse, 0);
    push(8'd79); check("l_relock_79", locked, 0);
    push(8'd80); check("l_relock_80", locked, 1);
    check("l_count_hold", err_count, 3);

    // Saturation via alternating bad/good words, then clear against a mismatch
    do_reset();
    push(8'd0); push(8'd1); push(8'd2); push(8'd3);
    v = 8'd3;
    for (int i = 0; i < 300; i++) begin
      v = v + 8'd2;
      push(v);
      if (i == 253) check("s_count_254", err_count, 254);
      if (i == 254) check("s_count_255", err_count, 255);
      v = v + 8'd1;
      push(v);
    end
    check("s_count_sat", err_count, 255);
    check("s_locked", locked, 1);
    v = v + 8'd5;
    push(v, 1'b1);
    check("s_clr_count", err_count, 0);
    check("s_clr_pulse", err_pulse, 1);
    check("s_clr_locked", locked, 1);

    // Asynchronous reset mid-stream
    do_reset();
    push(8'd10); push(8'd11); push(8'd12); push(8'd13);
    v = 8'd13;
    for (int i = 0; i < 5; i++) begin
      v = v + 8'd2;
      push(v);
      v = v + 8'd1;
      push(v);
    end
    check("m_pre_count", err_count, 5);
    check("m_pre_locked", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("m_locked", locked, 0);
    check("m_count", err_count, 0);
    check("m_expected", expected, 0);
    #1;
    rst_n = 1'b1;
    push(8'd40);
    check("m_first_locked", locked, 0);
    check("m_first_expected", expected, 41);
    push(8'd41); push(8'd42);
    check("m_run3", locked, 0);
    push(8'd43);
    check("m_run4", locked, 1);

    // Gapped stream
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(8'(10 + k));
      check("gap_locked", locked, (k == 3) ? 1 : 0);
      for (int g = 0; g < 7; g++) begin
        @(posedge clk);
        #1;
        check("gap_pulse", err_pulse, 0);
        check("gap_expected", expected, 11 + k);
        check("gap_hold", locked, (k == 3) ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
